// File: rtl/dm_port_arbiter.sv
// Two-master round-robin front end for the single-port data memory.
// It handles sub-word lane steering and alignment checks, and completes one access every three cycles.
module dm_port_arbiter #(
    parameter int MEM_ADDR_BITS = 10,
    parameter bit RR_INIT       = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     m0_req,
    input  logic                     m0_we,
    input  logic [1:0]               m0_size,
    input  logic [31:0]              m0_addr,
    input  logic [31:0]              m0_wdata,
    output logic                     m0_ack,
    output logic                     m0_err,
    output logic [31:0]              m0_rdata,
    input  logic                     m1_req,
    input  logic                     m1_we,
    input  logic [1:0]               m1_size,
    input  logic [31:0]              m1_addr,
    input  logic [31:0]              m1_wdata,
    output logic                     m1_ack,
    output logic                     m1_err,
    output logic [31:0]              m1_rdata,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic [3:0]               mem_be,
    output logic [31:0]              mem_wdata,
    output logic                     mem_we,
    input  logic [31:0]              mem_rdata,
    output logic                     busy
);
    localparam int AW = MEM_ADDR_BITS + 2;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t          state_reg, state_next;
    logic            win_reg, win_next;
    logic            ptr_reg, ptr_next;
    logic            we_reg, we_next;
    logic [1:0]      size_reg, size_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic [31:0]     wdata_reg, wdata_next;
    logic [31:0]     rdata0_reg, rdata0_next;
    logic [31:0]     rdata1_reg, rdata1_next;

    logic            illegal;
    logic            in_access;
    logic [3:0]      byte_be;
    logic [7:0]      rd_byte [4];
    logic [3:0]      be_dec;
    logic [31:0]     wdata_dec;
    logic [31:0]     load_data;

    // Address bits above the memory window are dropped on purpose so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[31:AW], m1_addr[31:AW]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = mem_rdata[8*gi +: 8];
            assign byte_be[gi] = (addr_reg[1:0] == 2'(gi));
        end
    endgenerate

    assign illegal = (size_reg == 2'd3)
                  || (size_reg == 2'd1 && addr_reg[0])
                  || (size_reg == 2'd2 && addr_reg[1:0] != 2'b00);

    always_comb begin
        be_dec    = 4'b0000;
        wdata_dec = wdata_reg;
        load_data = mem_rdata;
        case (size_reg)
            2'd0: begin
                be_dec    = byte_be;
                wdata_dec = {4{wdata_reg[7:0]}};
                load_data = {24'd0, rd_byte[addr_reg[1:0]]};
            end
            2'd1: begin
                be_dec    = addr_reg[1] ? 4'b1100 : 4'b0011;
                wdata_dec = {2{wdata_reg[15:0]}};
                load_data = addr_reg[1] ? {16'd0, mem_rdata[31:16]} : {16'd0, mem_rdata[15:0]};
            end
            2'd2: begin
                be_dec    = 4'b1111;
                wdata_dec = wdata_reg;
                load_data = mem_rdata;
            end
            default: begin
                be_dec    = 4'b0000;
                wdata_dec = wdata_reg;
                load_data = 32'd0;
            end
        endcase
        if (illegal) begin
            load_data = 32'd0;
        end
    end

    // Memory-side outputs are decoded from state so an async reset kills the write strobe at once.
    assign in_access = (state_reg == ACCESS);
    assign mem_addr  = in_access ? addr_reg[AW-1:2] : '0;
    assign mem_be    = in_access ? be_dec : 4'b0000;
    assign mem_wdata = in_access ? wdata_dec : 32'd0;
    assign mem_we    = in_access && we_reg && !illegal;

    assign m0_ack   = (state_reg == ACK) && !win_reg;
    assign m1_ack   = (state_reg == ACK) &&  win_reg;
    assign m0_err   = m0_ack && illegal;
    assign m1_err   = m1_ack && illegal;
    assign m0_rdata = rdata0_reg;
    assign m1_rdata = rdata1_reg;
    assign busy     = (state_reg != IDLE);

    always_comb begin
        state_next  = state_reg;
        win_next    = win_reg;
        ptr_next    = ptr_reg;
        we_next     = we_reg;
        size_next   = size_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        rdata0_next = rdata0_reg;
        rdata1_next = rdata1_reg;
        case (state_reg)
            IDLE: begin
                if (m0_req || m1_req) begin
                    win_next   = (m0_req && m1_req) ? ptr_reg : m1_req;
                    we_next    = win_next ? m1_we : m0_we;
                    size_next  = win_next ? m1_size : m0_size;
                    addr_next  = win_next ? m1_addr[AW-1:0] : m0_addr[AW-1:0];
                    wdata_next = win_next ? m1_wdata : m0_wdata;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // Legal stores leave the read-back register alone; anything illegal clears it.
                if (!we_reg || illegal) begin
                    if (win_reg) rdata1_next = load_data;
                    else         rdata0_next = load_data;
                end
                state_next = ACK;
            end
            ACK: begin
                ptr_next   = ~win_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            win_reg    <= 1'b0;
            ptr_reg    <= RR_INIT;
            we_reg     <= 1'b0;
            size_reg   <= 2'd0;
            addr_reg   <= '0;
            wdata_reg  <= 32'd0;
            rdata0_reg <= 32'd0;
            rdata1_reg <= 32'd0;
        end else begin
            state_reg  <= state_next;
            win_reg    <= win_next;
            ptr_reg    <= ptr_next;
            we_reg     <= we_next;
            size_reg   <= size_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            rdata0_reg <= rdata0_next;
            rdata1_reg <= rdata1_next;
        end
    end
endmodule
